simple_uart_rx: RTL

Serial receiver for the byte-stream path: 8N1 UART, LSB first, 16× oversampled. It recovers bytes from an asynchronous line and presents each one with a one-cycle strobe. It also keeps a 4-bit write address so received bytes can be stored in the 16-entry `memory`-style buffer. It is the receive-side counterpart of the `simpleUARTtx` / `counter` / `memory` transmit chain and sits directly behind the input pin, clocked by `sys_clk`.

---
 rtl/uart_pkg.sv | 10 +
 rtl/rx_tick_gen.sv | 16 +
 rtl/simple_uart_rx.sv | 98 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver constants and FSM state encoding
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
  localparam int TICKS_PER_BIT = 16;
  localparam int SAMPLE_A = 7;
  localparam int SAMPLE_B = 8;
  localparam int SAMPLE_C = 9;
  localparam int DATA_BITS = 8;
  localparam int OVS_DIV_DEFAULT = 156;
endpackage

// File: rtl/rx_tick_gen.sv
// rx_tick_gen: modulo-OVS_DIV oversample divider; restart_i realigns phase, tick_o pulses once per period
module rx_tick_gen #(
  parameter int OVS_DIV = 156
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic restart_i,
  output logic tick_o
);
  localparam int W = OVS_DIV > 1 ? $clog2(OVS_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick_o = cnt == W'(OVS_DIV - 1);
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) cnt <= '0;
    else cnt <= (restart_i || tick_o) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/simple_uart_rx.sv
// simple_uart_rx: 8N1 16x-oversampled receiver; line_i in, data_o/valid_o/ferr_o/busy_o/addr_o/wrap_o out
module simple_uart_rx
  import uart_pkg::*;
#(
  parameter int OVS_DIV = OVS_DIV_DEFAULT,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              line_i,
  output logic [7:0]        data_o,
  output logic              valid_o,
  output logic              ferr_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wrap_o
);
  state_t state;
  logic rx_m, rx_s, rx_q;
  logic [3:0] tcnt, tnxt;
  logic [2:0] bcnt;
  logic [DATA_BITS-1:0] sr;
  logic v_a, v_b, tick, fall, restart, decide, bit_d;
  assign fall = rx_q & ~rx_s;
  assign restart = (state == S_IDLE) && fall;
  assign tnxt = tcnt + 4'd1;
  assign decide = tick && tnxt == 4'(SAMPLE_C);
  assign bit_d = (v_a & v_b) | (v_a & rx_s) | (v_b & rx_s);
  rx_tick_gen #(.OVS_DIV(OVS_DIV)) u_tick (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .restart_i(restart),
    .tick_o(tick)
  );
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) {rx_m, rx_s, rx_q} <= 3'b111;
    else {rx_m, rx_s, rx_q} <= {line_i, rx_m, rx_s};
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state <= S_IDLE;
      tcnt <= '0;
      bcnt <= '0;
      sr <= '0;
      v_a <= 1'b0;
      v_b <= 1'b0;
      data_o <= '0;
      valid_o <= 1'b0;
      ferr_o <= 1'b0;
      busy_o <= 1'b0;
      addr_o <= '0;
      wrap_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      ferr_o <= 1'b0;
      wrap_o <= 1'b0;
      addr_o <= addr_o + ADDR_W'(valid_o);
      if (tick) begin
        tcnt <= tnxt;
        v_a <= tnxt == 4'(SAMPLE_A) ? rx_s : v_a;
        v_b <= tnxt == 4'(SAMPLE_B) ? rx_s : v_b;
      end
      case (state)
        S_IDLE:
          if (fall) begin
            state <= S_START;
            tcnt <= '0;
            bcnt <= '0;
            busy_o <= 1'b1;
          end
        S_START:
          if (decide) begin
            state <= bit_d ? S_IDLE : S_DATA;
            busy_o <= ~bit_d;
          end
        S_DATA:
          if (decide) begin
            sr <= {bit_d, sr[DATA_BITS-1:1]};
            bcnt <= bcnt + 3'd1;
            state <= bcnt == 3'(DATA_BITS - 1) ? S_STOP : S_DATA;
          end
        S_STOP:
          if (decide) begin
            state <= bit_d ? S_IDLE : S_BREAK;
            busy_o <= ~bit_d;
            valid_o <= bit_d;
            ferr_o <= ~bit_d;
            wrap_o <= bit_d & (&addr_o);
            data_o <= bit_d ? sr : data_o;
          end
        S_BREAK:
          if (rx_s) begin
            state <= S_IDLE;
            busy_o <= 1'b0;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule
